secretkey_bram_reader: RTL and testbench

// - Reads the PA-finished secret key out of Bob's 64b x 32768 secret-key BRAM (port B) and streams it out as 64-bit words.
// - Sits beside the Bob core on clock_100M and is the reader end of the secret-key BRAM that the Bob PA engine writes.
// - Kicked by a start pulse (normally B_pa_finish); ends with rd_done, or with rd_fail on an illegal length.

---
 rtl/secretkey_bram_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_secretkey_bram_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/secretkey_bram_reader.sv
// Streams the PA-finished secret key out of port B of Bob's secret-key BRAM as 64-bit words.
// Define SECRETKEY_ZEROIZE_EN to have the read-out followed by a zero-write of every word it read.
module secretkey_bram_reader #(
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int HALF_WORDS = 16384
) (
   input  logic        clock_100M,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] secretkey_length,
   input  logic        key_addr_index,
   output logic [14:0] bram_addrb,
   output logic        bram_enb,
   input  logic [63:0] bram_doutb,
   output logic [7:0]  bram_web,
   output logic [63:0] bram_dinb,
   output logic [63:0] key_tdata,
   output logic        key_tvalid,
   input  logic        key_tready,
   output logic        key_tlast,
   output logic        busy,
   output logic        rd_done,
   output logic        rd_fail
);

   // state | meaning
   // IDLE  | waiting for start
   // CHECK | one cycle to validate the latched length
   // READ  | issuing BRAM reads, throttled by FIFO room
   // DRAIN | all reads issued, waiting for the FIFO to empty
   // ZERO  | writing zeros over the words just read (zeroize builds only)
   // DONE  | rd_done pulse
   // FAIL  | rd_fail pulse, no BRAM access
   localparam int CNT_W  = $clog2(HALF_WORDS + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE, CHECK, READ, DRAIN,
`ifdef SECRETKEY_ZEROIZE_EN
      ZERO,
`endif
      DONE, FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         len_q, len_d;
   logic [14:0]         base_q, base_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]    push_idx_q, push_idx_d;
   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [63:0]         mem_q [FIFO_DEPTH];
   logic [63:0]         mem_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_q, last_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   count_q, count_d;
   logic [14:0]         addr_q, addr_d;
   logic                enb_q, enb_d;
   logic [63:0]         tdata_q, tdata_d;
   logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
`ifdef SECRETKEY_ZEROIZE_EN
   logic [7:0]          web_q, web_d;
`endif

   logic [32:0] n_full;
   logic        len_ok, rd_issue, push, pop, push_last, issue_next;
   logic [63:0] push_mask;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      base_d     = base_q;
      n_d        = n_q;
      rd_cnt_d   = rd_cnt_q;
      push_idx_d = push_idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_d      = mem_q;
      last_d     = last_q;
      addr_d     = addr_q;

      n_full    = ({1'b0, len_q} + 33'd63) >> 6;
      len_ok    = (len_q != '0) && (n_full <= 33'(HALF_WORDS));
      rd_issue  = enb_q && (state_q == READ);
      push      = vld_q[RD_LATENCY-1];
      pop       = tvalid_q && key_tready;
      push_last = (push_idx_q == n_q - CNT_W'(1));
      push_mask = (push_last && (len_q[5:0] != 6'd0)) ? ((64'd1 << len_q[5:0]) - 64'd1) : '1;

      // the masked tail is applied on the way in so the FIFO holds final words
      if (push) begin
         mem_d[wr_ptr_q]  = bram_doutb & push_mask;
         last_d[wr_ptr_q] = push_last;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         push_idx_d       = push_idx_q + CNT_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + FCNT_W'(1);
      else if (!push && pop) count_d = count_q - FCNT_W'(1);
      vld_d = RD_LATENCY'({vld_q, rd_issue});

      case (state_q)
         IDLE: if (start) begin
            state_d = CHECK;
            len_d   = secretkey_length;
            base_d  = key_addr_index ? 15'(HALF_WORDS) : 15'd0;
         end
         CHECK: if (!len_ok) state_d = FAIL;
         else begin
            state_d    = READ;
            n_d        = n_full[CNT_W-1:0];
            rd_cnt_d   = '0;
            push_idx_d = '0;
         end
         READ: if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == n_q - CNT_W'(1)) state_d = DRAIN;
         end
         DRAIN: if ((count_q == '0) && (vld_q == '0)) begin
`ifdef SECRETKEY_ZEROIZE_EN
            state_d  = ZERO;
            rd_cnt_d = '0;
`else
            state_d  = DONE;
`endif
         end
`ifdef SECRETKEY_ZEROIZE_EN
         ZERO: if (rd_cnt_q == n_q - CNT_W'(1)) state_d = DONE;
         else rd_cnt_d = rd_cnt_q + CNT_W'(1);
`endif
         DONE:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // the enable is decided a cycle ahead from next-cycle occupancy so it can be a flop
      issue_next = (state_d == READ) && (rd_cnt_d < n_d)
                   && ((32'(count_d) + $countones(vld_d)) < FIFO_DEPTH);
`ifdef SECRETKEY_ZEROIZE_EN
      enb_d = issue_next || (state_d == ZERO);
      web_d = (state_d == ZERO) ? 8'hFF : 8'h00;
`else
      enb_d = issue_next;
`endif
      if (enb_d) addr_d = base_q + 15'(rd_cnt_d);

      tvalid_d = (count_d != '0);
      tdata_d  = mem_d[rd_ptr_d];
      tlast_d  = last_d[rd_ptr_d];
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      fail_d   = (state_d == FAIL);
   end

   always_ff @(posedge clock_100M or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         base_q     <= '0;
         n_q        <= '0;
         rd_cnt_q   <= '0;
         push_idx_q <= '0;
         vld_q      <= '0;
         mem_q      <= '{default: '0};
         last_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         addr_q     <= '0;
         enb_q      <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
`ifdef SECRETKEY_ZEROIZE_EN
         web_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         base_q     <= base_d;
         n_q        <= n_d;
         rd_cnt_q   <= rd_cnt_d;
         push_idx_q <= push_idx_d;
         vld_q      <= vld_d;
         mem_q      <= mem_d;
         last_q     <= last_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         enb_q      <= enb_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
`ifdef SECRETKEY_ZEROIZE_EN
         web_q      <= web_d;
`endif
      end
   end

   assign bram_addrb = addr_q;
   assign bram_enb   = enb_q;
   assign bram_dinb  = '0;
`ifdef SECRETKEY_ZEROIZE_EN
   assign bram_web   = web_q;
`else
   assign bram_web   = 8'h00;
`endif
   assign key_tdata  = tdata_q;
   assign key_tvalid = tvalid_q;
   assign key_tlast  = tlast_q;
   assign busy       = busy_q;
   assign rd_done    = done_q;
   assign rd_fail    = fail_q;

endmodule

// File: tb/tb_secretkey_bram_reader.sv
// Bench for secretkey_bram_reader: BRAM model, expected-word scoreboard, address and handshake monitors.
module tb_secretkey_bram_reader;

   logic        clock_100M, reset, start, key_addr_index, key_tready;
   logic [31:0] secretkey_length;
   logic [14:0] bram_addrb;
   logic        bram_enb, key_tvalid, key_tlast, busy, rd_done, rd_fail;
   logic [63:0] bram_doutb, bram_dinb, key_tdata;
   logic [7:0]  bram_web;

   secretkey_bram_reader dut (
      .clock_100M(clock_100M), .reset(reset), .start(start),
      .secretkey_length(secretkey_length), .key_addr_index(key_addr_index),
      .bram_addrb(bram_addrb), .bram_enb(bram_enb), .bram_doutb(bram_doutb),
      .bram_web(bram_web), .bram_dinb(bram_dinb),
      .key_tdata(key_tdata), .key_tvalid(key_tvalid), .key_tready(key_tready),
      .key_tlast(key_tlast), .busy(busy), .rd_done(rd_done), .rd_fail(rd_fail)
   );

   initial clock_100M = 1'b0;
   always #5 clock_100M = ~clock_100M;

   int total = 0, bad = 0, cyc = 0;
   int enb_cnt = 0, run_len = 0, max_run = 0, words = 0;
   int done_cnt = 0, fail_cnt = 0, tv_cnt = 0, done_cyc = 0, zw_cnt = 0, zw_cyc = 0;
   int tr_mode = 0;
   logic        stalled = 1'b0;
   logic [63:0] held;
   logic [64:0] e_mon;
   logic [64:0] exp_q[$];
   int          exp_addr[$];
   int          exp_zaddr[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // BRAM: two-stage read pipeline, full-word zero writes, bulk fill on request
   logic [63:0] bmem [0:32767];
   logic [63:0] rd_p1 = '0, rd_p2 = '0;
   logic        fill_req = 1'b0, fill_ones = 1'b0;

   function automatic logic [63:0] pat(input int a);
      return {16'hC0DE, 16'(a), 32'(a) * 32'h9E37_79B1};
   endfunction

   always @(posedge clock_100M) begin
      if (fill_req) begin
         for (int a = 0; a < 32768; a++) bmem[a] <= fill_ones ? 64'hFFFF_FFFF_FFFF_FFFF : pat(a);
      end else if (bram_enb) begin
         if (bram_web == 8'hFF) bmem[bram_addrb] <= bram_dinb;
         else rd_p1 <= bmem[bram_addrb];
      end
      rd_p2 <= rd_p1;
   end
   assign bram_doutb = rd_p2;

   always @(posedge clock_100M) cyc <= cyc + 1;

   initial begin
      key_tready = 1'b0;
      forever begin
         @(posedge clock_100M); #1;
         case (tr_mode)
            0:       key_tready = 1'b1;
            1:       key_tready = 1'($urandom_range(0, 1));
            default: key_tready = 1'b0;
         endcase
      end
   end

   always @(negedge clock_100M) begin
      if (reset) begin
         stalled = 1'b0;
         run_len = 0;
      end else begin
         if (bram_enb && bram_web == 8'h00) begin
            enb_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_addr.size() > 0) chk("rd_addr", 64'(bram_addrb), 64'(exp_addr.pop_front()));
            else chk("rd_extra", 64'(exp_addr.size()), 64'd1);
         end else run_len = 0;
`ifdef SECRETKEY_ZEROIZE_EN
         if (bram_enb && bram_web == 8'hFF) begin
            zw_cnt++;
            zw_cyc = cyc;
            if (exp_zaddr.size() > 0) chk("zero_addr", 64'(bram_addrb), 64'(exp_zaddr.pop_front()));
            else chk("zero_extra", 64'(exp_zaddr.size()), 64'd1);
            chk("zero_din", bram_dinb, 64'd0);
         end
`else
         if (bram_enb) chk("web_tied", 64'(bram_web), 64'd0);
`endif
         if (stalled) begin
            chk("stall_valid", 64'(key_tvalid), 64'd1);
            if (key_tvalid) chk("stall_data", key_tdata, held);
         end
         stalled = 1'b0;
         if (key_tvalid) begin
            tv_cnt++;
            if (key_tready) begin
               if (exp_q.size() > 0) begin
                  e_mon = exp_q.pop_front();
                  chk("word", key_tdata, e_mon[63:0]);
                  chk("last", 64'(key_tlast), 64'(e_mon[64]));
               end else chk("word_extra", 64'(exp_q.size()), 64'd1);
               words++;
            end else begin
               stalled = 1'b1;
               held    = key_tdata;
            end
         end
         if (rd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_fail) fail_cnt++;
      end
   end

   task automatic fill(input logic ones);
      @(posedge clock_100M); #1;
      fill_ones = ones;
      fill_req  = 1'b1;
      @(posedge clock_100M); #1;
      fill_req  = 1'b0;
   endtask

   function automatic int n_of(input logic [31:0] len);
      longint l;
      l = longint'(len);
      return int'((l + 63) / 64);
   endfunction

   task automatic expect_run(input logic [31:0] len, input logic idx);
      int n, base, r;
      logic [63:0] w;
      n    = n_of(len);
      base = idx ? 16384 : 0;
      r    = int'(len % 64);
      for (int k = 0; k < n; k++) begin
         w = bmem[base + k];
         if (k == n - 1 && r != 0) w = w & ((64'd1 << r) - 64'd1);
         exp_q.push_back({(k == n - 1), w});
         exp_addr.push_back(base + k);
         exp_zaddr.push_back(base + k);
      end
   endtask

   task automatic kick(input logic [31:0] len, input logic idx);
      @(posedge clock_100M); #1;
      secretkey_length = len;
      key_addr_index   = idx;
      start            = 1'b1;
      @(posedge clock_100M); #1;
      start            = 1'b0;
   endtask

   task automatic wait_end(input int budget, input int d0, input int f0, input string tag);
      int i;
      i = 0;
      while (done_cnt == d0 && fail_cnt == f0 && i < budget) begin
         @(posedge clock_100M);
         i++;
      end
      if (done_cnt == d0 && fail_cnt == f0) chk({tag, "_timeout"}, 64'(done_cnt - d0), 64'd1);
      repeat (3) @(posedge clock_100M);
      #1;
   endtask

   task automatic run(input logic [31:0] len, input logic idx, input int budget, input string tag);
      int d0, f0, w0;
      d0 = done_cnt; f0 = fail_cnt; w0 = words;
      expect_run(len, idx);
      kick(len, idx);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      wait_end(budget, d0, f0, tag);
      chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, "_fail"}, 64'(fail_cnt - f0), 64'd0);
      chk({tag, "_words"}, 64'(words - w0), 64'(n_of(len)));
      chk({tag, "_left"}, 64'(exp_q.size() + exp_addr.size()), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic bad_len(input logic [31:0] len, input string tag);
      int e0, t0, d0, f0, lat;
      e0 = enb_cnt; t0 = tv_cnt; d0 = done_cnt; f0 = fail_cnt;
      kick(len, 1'b1);
      lat = 1;
      while (!rd_fail && lat < 10) begin
         @(posedge clock_100M); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd2);
      repeat (5) @(posedge clock_100M);
      #1;
      chk({tag, "_fail"}, 64'(fail_cnt - f0), 64'd1);
      chk({tag, "_done"}, 64'(done_cnt - d0), 64'd0);
      chk({tag, "_enb"}, 64'(enb_cnt - e0), 64'd0);
      chk({tag, "_tvalid"}, 64'(tv_cnt - t0), 64'd0);
   endtask

   int e_hold, w5, f_ign, z0;

   initial begin
      reset = 1'b1; start = 1'b0; secretkey_length = '0; key_addr_index = 1'b0;
      repeat (3) @(posedge clock_100M);
      #1;
      chk("rst_ctl", 64'({bram_addrb, bram_enb, bram_web, key_tvalid, key_tlast, busy, rd_done, rd_fail}), 64'd0);
      chk("rst_data", key_tdata, 64'd0);
      reset = 1'b0;

      fill(1'b0);
      run(32'd4096, 1'b0, 400, "t4096");
      chk("t4096_run", 64'(max_run), 64'd64);

      fill(1'b1);
      run(32'd100, 1'b1, 100, "t100");

      bad_len(32'd0, "len0");
      bad_len(32'd1048577, "lenmax1");

      fill(1'b0);
      run(32'd1048576, 1'b1, 40000, "lenmax");

      tr_mode = 2;
      e_hold  = enb_cnt;
      fork
         run(32'd640, 1'b0, 600, "t640");
         begin
            repeat (21) @(posedge clock_100M);
            chk("t640_full_enb", 64'(enb_cnt - e_hold), 64'd4);
            tr_mode = 1;
         end
      join
      tr_mode = 0;

      f_ign = fail_cnt;
      w5    = words;
      expect_run(32'd4096, 1'b0);
      kick(32'd4096, 1'b0);
      repeat (2) @(posedge clock_100M);
      kick(32'd0, 1'b0);
      for (int i = 0; i < 200 && words < w5 + 5; i++) @(posedge clock_100M);
      chk("t5_word5", 64'(words - w5 >= 5), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("t5_ign", 64'(fail_cnt - f_ign), 64'd0);
      chk("t5_rst_ctl", 64'({bram_addrb, bram_enb, bram_web, key_tvalid, key_tlast, busy, rd_done, rd_fail}), 64'd0);
      chk("t5_rst_data", key_tdata, 64'd0);
      exp_q.delete();
      exp_addr.delete();
      exp_zaddr.delete();
      repeat (2) @(posedge clock_100M);
      #2 reset = 1'b0;
      run(32'd128, 1'b0, 100, "t128");

`ifdef SECRETKEY_ZEROIZE_EN
      fill(1'b0);
      z0 = zw_cnt;
      run(32'd256, 1'b0, 200, "zero");
      chk("zero_cnt", 64'(zw_cnt - z0), 64'd4);
      chk("zero_done_lat", 64'(done_cyc - zw_cyc), 64'd1);
      chk("zero_left", 64'(exp_zaddr.size()), 64'd0);
      for (int k = 0; k < 4; k++) chk("zero_rb", bmem[k], 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
